axil_reg_slave: RTL and testbench
=================================

// Module: axil_reg_slave
// PURPOSE
//  AXI4-Lite responder (slave) holding a control/status register bank for the rfsoc fabric.
//  Answers WriteReg/ReadReg transactions issued by the AXI4-Lite master in the sim testbench and by the PS.
//  N_RW read/write control regs drive fabric logic; N_RO read-only status regs are sampled from fabric inputs.
// PARAMETERS
//  ADDR_W   12   AXI address width; word index = addr[ADDR_W-1:2], addr[1:0] ignored
//  N_RW     8    control regs, offsets 0x000 + 4*i
//  N_RO     8    status regs, offsets RO_BASE + 4*i
//  RO_BASE  'h100 byte offset of first status reg; must be > 4*N_RW and 4-aligned
//  RST_VAL  '0   reset value of every control reg (32b)
// PORTS
//  axilite_clk  in   1          single clock, all logic rising-edge
//  axilite_rst  in   1          synchronous, active-high reset
//  awaddr/awprot/awvalid in ADDR_W/3/1; awready out 1
//  wdata/wstrb/wvalid    in 32/4/1;     wready  out 1
//  bresp out 2; bvalid out 1; bready in 1
//  araddr/arprot/arvalid in ADDR_W/3/1; arready out 1
//  rdata out 32; rresp out 2; rvalid out 1; rready in 1
//  ctrl_regs    out  32*N_RW    flattened control regs, reg i at [32*i+:32]
//  ctrl_wr_stb  out  N_RW       1-cycle pulse the cycle after reg i is written
//  status_in    in   32*N_RO    status values, sampled when the read address is accepted
// BEHAVIOUR
//  Reset: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, ctrl_regs=RST_VAL, ctrl_wr_stb=0.
//  awprot/arprot are ignored.
//  Write FSM states: W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
//   W_IDLE: awvalid&wvalid -> pulse awready and wready for 1 cycle, commit write, go W_RESP.
//           awvalid only -> pulse awready, latch addr, go W_WAIT_W.
//           wvalid only  -> pulse wready, latch data/strb, go W_WAIT_AW.
//   W_WAIT_W / W_WAIT_AW: on the missing valid, pulse its ready, commit write, go W_RESP.
//   Commit: byte k of the target reg is written iff wstrb[k]; ctrl_wr_stb[i] pulses the next cycle.
//           wstrb=0 is a legal no-op: no strobe pulse, response still sent.
//   W_RESP: bvalid=1 held until bready; bvalid&bready -> bvalid=0, go W_IDLE. One outstanding write maximum.
//   Write latency: commit on the cycle both halves are captured; bvalid rises the next cycle.
//  Read FSM states: R_IDLE, R_DATA.
//   R_IDLE: arvalid -> pulse arready 1 cycle; rdata registered from the addressed reg or status_in; go R_DATA.
//   R_DATA: rvalid=1; rdata/rresp held stable until rready; rvalid&rready -> rvalid=0, go R_IDLE.
//   Read latency: rvalid rises the cycle after the arready pulse.
//  Every ready is a single-cycle pulse, never held high. A master that waits for an edge on ready sees exactly one edge.
//  Read and write channels are fully independent and may complete in the same cycle.
//   Same-cycle read capture and write commit to the same reg: rdata returns the pre-write value.
//  Unmapped addresses (not in the RW or RO range): writes are dropped; reads return 32'h0.
//  Writes to the RO range are dropped; the response is still generated.
//  Reset asserted mid-transaction: both FSMs return to idle; pending responses are discarded; regs return to RST_VAL.
// CONFIGURATION
//  AXIL_SLVERR_EN defined:
//   unmapped accesses and writes to the RO range return bresp/rresp = 2'b10 (SLVERR).
//  AXIL_SLVERR_EN undefined:
//   every response is 2'b00 (OKAY); drop/zero semantics are unchanged.
// TESTING
//  1 reset, then read 0x000..0x01C -> each rdata=RST_VAL, rresp=OKAY, no ctrl_wr_stb.
//  2 WriteReg(0x004,32'hDEADBEEF) then ReadReg(0x004) -> ctrl_regs[63:32]=DEADBEEF;
//    ctrl_wr_stb[1] high exactly 1 cycle; readback DEADBEEF.
//  3 write 0x008=FFFFFFFF, then 0x008=00000000 with wstrb=4'b0101 -> readback FF00FF00.
//  4 status_in[0+:32]=0x12345678, ReadReg(0x100) -> 12345678.
//    WriteReg(0x100,0) -> status unchanged; bresp SLVERR with AXIL_SLVERR_EN, else OKAY.
//  5 wvalid before awvalid (W_WAIT_AW path); bready held low 5 cycles -> bvalid stays 1 until bready.
//    rready held low 5 cycles -> rdata stable; each ready pulses once.
//  6 ReadReg(0x3FC) -> rdata=0, rresp SLVERR/OKAY per macro.
//    Reset asserted while bvalid=1 -> bvalid=0 next cycle, regs return to RST_VAL.

Source files
------------

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: N_RW control regs (read/write) and N_RO status regs (read-only).
// Define AXIL_SLVERR_EN to return SLVERR for unmapped accesses and writes to the status range.
module axil_reg_slave #(
  parameter int          ADDR_W  = 12,
  parameter int          N_RW    = 8,
  parameter int          N_RO    = 8,
  parameter int          RO_BASE = 'h100,
  parameter logic [31:0] RST_VAL = '0
) (
  input  logic                axilite_clk,
  input  logic                axilite_rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic [32*N_RW-1:0]  ctrl_regs,
  output logic [N_RW-1:0]     ctrl_wr_stb,
  input  logic [32*N_RO-1:0]  status_in
);

  localparam int RO_LO = RO_BASE / 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] RESP_BAD = 2'b10;
`else
  localparam logic [1:0] RESP_BAD = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] word_idx(input logic [ADDR_W-1:0] a);
    return 32'(a[ADDR_W-1:2]);
  endfunction

  function automatic logic is_rw(input logic [31:0] w);
    return w < N_RW;
  endfunction

  function automatic logic is_ro(input logic [31:0] w);
    return (w >= RO_LO) && (w < RO_LO + N_RO);
  endfunction

  wr_state_t         wr_state_reg, wr_state_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [31:0]       wr_data_reg, wr_data_next;
  logic [3:0]        wr_strb_reg, wr_strb_next;
  logic [1:0]        bresp_reg, bresp_next;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;
  logic [31:0]       commit_widx;

  rd_state_t         rd_state_reg, rd_state_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic [31:0]       rd_widx;
  logic [31:0]       rd_val;

  logic [31:0]       ctrl_mem_reg [N_RW];
  logic [N_RW-1:0]   ctrl_wr_stb_reg;

  logic              unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // Write FSM: ready is combinational on valid, so it is high for exactly the handshake cycle.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    wr_strb_next  = wr_strb_reg;
    bresp_next    = bresp_reg;
    awready       = 1'b0;
    wready        = 1'b0;
    commit        = 1'b0;
    commit_addr   = awaddr;
    commit_data   = wdata;
    commit_strb   = wstrb;
    case (wr_state_reg)
      W_IDLE: begin
        if (awvalid && wvalid) begin
          awready = 1'b1;
          wready  = 1'b1;
          commit  = 1'b1;
        end else if (awvalid) begin
          awready       = 1'b1;
          wr_addr_next  = awaddr;
          wr_state_next = W_WAIT_W;
        end else if (wvalid) begin
          wready        = 1'b1;
          wr_data_next  = wdata;
          wr_strb_next  = wstrb;
          wr_state_next = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (wvalid) begin
          wready      = 1'b1;
          commit      = 1'b1;
          commit_addr = wr_addr_reg;
        end
      end
      W_WAIT_AW: begin
        if (awvalid) begin
          awready     = 1'b1;
          commit      = 1'b1;
          commit_data = wr_data_reg;
          commit_strb = wr_strb_reg;
        end
      end
      W_RESP: begin
        if (bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
    if (axilite_rst) begin
      awready = 1'b0;
      wready  = 1'b0;
      commit  = 1'b0;
    end
    if (commit) begin
      wr_state_next = W_RESP;
      bresp_next    = is_rw(word_idx(commit_addr)) ? RESP_OKAY : RESP_BAD;
    end
  end

  assign commit_widx = word_idx(commit_addr);
  assign bvalid      = (wr_state_reg == W_RESP);
  assign bresp       = bresp_reg;

  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      wr_state_reg <= W_IDLE;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      wr_strb_reg  <= '0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      wr_strb_reg  <= wr_strb_next;
      bresp_reg    <= bresp_next;
    end
  end

  // Byte-masked commit; the strobe is suppressed for an all-zero wstrb.
  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      for (int i = 0; i < N_RW; i++) ctrl_mem_reg[i] <= RST_VAL;
      ctrl_wr_stb_reg <= '0;
    end else begin
      for (int i = 0; i < N_RW; i++) begin
        ctrl_wr_stb_reg[i] <= commit && (commit_widx == i) && (|commit_strb);
        if (commit && (commit_widx == i)) begin
          for (int k = 0; k < 4; k++) begin
            if (commit_strb[k]) ctrl_mem_reg[i][8*k +: 8] <= commit_data[8*k +: 8];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_RW; gi++) begin : g_ctrl_out
      assign ctrl_regs[32*gi +: 32] = ctrl_mem_reg[gi];
    end
  endgenerate
  assign ctrl_wr_stb = ctrl_wr_stb_reg;

  always_comb begin
    rd_widx = word_idx(araddr);
    rd_val  = '0;
    for (int i = 0; i < N_RW; i++) begin
      if (rd_widx == i) rd_val = ctrl_mem_reg[i];
    end
    for (int i = 0; i < N_RO; i++) begin
      if (rd_widx == RO_LO + i) rd_val = status_in[32*i +: 32];
    end
  end

  // Read FSM: capture uses the register value before any same-cycle commit.
  always_comb begin
    rd_state_next = rd_state_reg;
    rdata_next    = rdata_reg;
    rresp_next    = rresp_reg;
    arready       = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        if (arvalid && !axilite_rst) begin
          arready       = 1'b1;
          rdata_next    = rd_val;
          rresp_next    = (is_rw(rd_widx) || is_ro(rd_widx)) ? RESP_OKAY : RESP_BAD;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      rd_state_reg <= R_IDLE;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      rdata_reg    <= rdata_next;
      rresp_reg    <= rresp_next;
    end
  end

  assign rvalid = (rd_state_reg == R_DATA);
  assign rdata  = rdata_reg;
  assign rresp  = rresp_reg;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave; honours AXIL_SLVERR_EN for the expected error response.
module tb_axil_reg_slave;

`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic         axilite_clk = 1'b0;
  logic         axilite_rst = 1'b1;
  logic [11:0]  awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [11:0]  araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [255:0] ctrl_regs;
  logic [7:0]   ctrl_wr_stb;
  logic [255:0] status_in = '0;

  axil_reg_slave dut (
    .axilite_clk (axilite_clk),
    .axilite_rst (axilite_rst),
    .awaddr      (awaddr),
    .awprot      (awprot),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .araddr      (araddr),
    .arprot      (arprot),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .ctrl_regs   (ctrl_regs),
    .ctrl_wr_stb (ctrl_wr_stb),
    .status_in   (status_in)
  );

  always #5 axilite_clk = ~axilite_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int aw_pulses = 0;
  int w_pulses  = 0;
  int ar_pulses = 0;
  int stb_cnt [8];

  // Count ready pulses and strobe cycles mid-cycle, clear of both clock edges.
  always begin
    @(negedge axilite_clk);
    #2;
    if (awready) aw_pulses++;
    if (wready)  w_pulses++;
    if (arready) ar_pulses++;
    for (int i = 0; i < 8; i++) if (ctrl_wr_stb[i]) stb_cnt[i]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Both tasks are entered on a negedge and return on a negedge.
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, b_seen;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge axilite_clk);
      @(negedge axilite_clk);
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", 32'(aw_done && w_done), 1);
    b_seen = 1'b0; resp = 2'b11;
    for (int n = 0; n < 20 && !b_seen; n++) begin
      if (bvalid) begin b_seen = 1'b1; resp = bresp; end
      @(posedge axilite_clk);
      @(negedge axilite_clk);
    end
    bready = 1'b0;
    check("wr_bvalid", 32'(b_seen), 1);
    $display("WR addr=%03h data=%08h strb=%b bresp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done, ar_hs, r_seen;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    ar_done = 1'b0;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      #1;
      ar_hs = arvalid && arready;
      @(posedge axilite_clk);
      @(negedge axilite_clk);
      if (ar_hs) begin arvalid = 1'b0; ar_done = 1'b1; end
    end
    arvalid = 1'b0;
    check("rd_handshake", 32'(ar_done), 1);
    r_seen = 1'b0; data = 32'hxxxxxxxx; resp = 2'b11;
    for (int n = 0; n < 20 && !r_seen; n++) begin
      if (rvalid) begin r_seen = 1'b1; data = rdata; resp = rresp; end
      @(posedge axilite_clk);
      @(negedge axilite_clk);
    end
    rready = 1'b0;
    check("rd_rvalid", 32'(r_seen), 1);
    $display("RD addr=%03h rdata=%08h rresp=%b", addr, data, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, first;
    logic [1:0]  r;
    int s0, s1, a0, w0, hold;

    for (int i = 0; i < 8; i++) stb_cnt[i] = 0;

    // Reset with every valid asserted: no ready may respond.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge axilite_clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", {bresp, rresp}, 0);
    check("rst_stb", ctrl_wr_stb, 0);
    @(negedge axilite_clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    axilite_rst = 1'b0;
    @(negedge axilite_clk);

    // 1: control regs read back as reset value
    for (int i = 0; i < 8; i++) begin
      axi_read(12'(4 * i), d, r);
      check($sformatf("t1_rdata%0d", i), d, 0);
      check($sformatf("t1_rresp%0d", i), r, 0);
    end
    s0 = 0;
    for (int i = 0; i < 8; i++) s0 += stb_cnt[i];
    check("t1_no_stb", s0, 0);

    // 2: full write and readback
    s1 = stb_cnt[1];
    axi_write(12'h004, 32'hDEADBEEF, 4'hF, r);
    check("t2_bresp", r, 0);
    repeat (2) @(negedge axilite_clk);
    check("t2_ctrl1", ctrl_regs[63:32], 32'hDEADBEEF);
    check("t2_stb1_cycles", stb_cnt[1] - s1, 1);
    check("t2_stb0_none", stb_cnt[0], 0);
    axi_read(12'h004, d, r);
    check("t2_readback", d, 32'hDEADBEEF);

    // 3: byte strobes, then a zero-strobe no-op
    axi_write(12'h008, 32'hFFFFFFFF, 4'hF, r);
    axi_write(12'h008, 32'h00000000, 4'b0101, r);
    axi_read(12'h008, d, r);
    check("t3_strb_mix", d, 32'hFF00FF00);
    s1 = stb_cnt[2];
    axi_write(12'h008, 32'h12345678, 4'b0000, r);
    check("t3_strb0_bresp", r, 0);
    repeat (2) @(negedge axilite_clk);
    check("t3_strb0_no_stb", stb_cnt[2] - s1, 0);
    check("t3_strb0_value", ctrl_regs[95:64], 32'hFF00FF00);

    // 4: status range and unmapped accesses
    status_in[31:0]    = 32'h12345678;
    status_in[255:224] = 32'hCAFEF00D;
    axi_read(12'h100, d, r);
    check("t4_status0", d, 32'h12345678);
    check("t4_status0_rresp", r, 0);
    axi_write(12'h100, 32'h00000000, 4'hF, r);
    check("t4_ro_bresp", r, ERR_RESP);
    axi_read(12'h100, d, r);
    check("t4_status0_after", d, 32'h12345678);
    axi_read(12'h11C, d, r);
    check("t4_status7", d, 32'hCAFEF00D);
    axi_read(12'h0FC, d, r);
    check("t4_gap_rdata", d, 0);
    check("t4_gap_rresp", r, ERR_RESP);
    s0 = 0;
    for (int i = 0; i < 8; i++) s0 += stb_cnt[i];
    axi_write(12'h020, 32'h5A5A5A5A, 4'hF, r);
    check("t4_unmapped_bresp", r, ERR_RESP);
    repeat (2) @(negedge axilite_clk);
    s1 = 0;
    for (int i = 0; i < 8; i++) s1 += stb_cnt[i];
    check("t4_unmapped_no_stb", s1 - s0, 0);
    check("t4_ctrl0_intact", ctrl_regs[31:0], 0);

    // 5: data before address, response held off by bready
    a0 = aw_pulses; w0 = w_pulses;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    #1;
    check("t5_wready_first", wready, 1);
    check("t5_awready_idle", awready, 0);
    @(posedge axilite_clk); @(negedge axilite_clk);
    wvalid = 1'b0;
    repeat (2) @(negedge axilite_clk);
    awaddr = 12'h00C; awvalid = 1'b1;
    #1;
    check("t5_awready_late", awready, 1);
    @(posedge axilite_clk); @(negedge axilite_clk);
    awvalid = 1'b0;
    hold = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (bvalid) hold++;
      @(negedge axilite_clk);
    end
    check("t5_bvalid_held", hold, 5);
    bready = 1'b1;
    @(posedge axilite_clk); @(negedge axilite_clk);
    bready = 1'b0;
    #1;
    check("t5_bvalid_cleared", bvalid, 0);
    repeat (2) @(negedge axilite_clk);
    check("t5_aw_pulses", aw_pulses - a0, 1);
    check("t5_w_pulses", w_pulses - w0, 1);
    check("t5_ctrl3", ctrl_regs[127:96], 32'h0BADF00D);
    $display("WR addr=00c data=0badf00d strb=1111 (data first, bready delayed)");

    a0 = ar_pulses;
    araddr = 12'h004; arvalid = 1'b1; rready = 1'b0;
    @(posedge axilite_clk); @(negedge axilite_clk);
    arvalid = 1'b0;
    first = rdata;
    hold = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (rvalid && rdata === first) hold++;
      @(negedge axilite_clk);
    end
    check("t5_rdata_value", first, 32'hDEADBEEF);
    check("t5_rdata_stable", hold, 5);
    rready = 1'b1;
    @(posedge axilite_clk); @(negedge axilite_clk);
    rready = 1'b0;
    #1;
    check("t5_rvalid_cleared", rvalid, 0);
    repeat (2) @(negedge axilite_clk);
    check("t5_ar_pulses", ar_pulses - a0, 1);
    $display("RD addr=004 rdata=%08h (rready delayed)", first);

    // Same-cycle read capture and write commit to reg 4
    awaddr = 12'h010; awvalid = 1'b1; wdata = 32'hA5A50001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    araddr = 12'h010; arvalid = 1'b1; rready = 1'b1;
    #1;
    check("sc_both_ready", 32'(awready && wready && arready), 1);
    @(posedge axilite_clk); @(negedge axilite_clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("sc_rdata_prewrite", rdata, 0);
    check("sc_ctrl4_written", ctrl_regs[159:128], 32'hA5A50001);
    check("sc_both_valid", 32'(bvalid && rvalid), 1);
    @(posedge axilite_clk); @(negedge axilite_clk);
    bready = 1'b0; rready = 1'b0;
    check("sc_both_done", 32'(bvalid || rvalid), 0);
    $display("WR+RD addr=010 data=a5a50001 same cycle");
    axi_read(12'h010, d, r);
    check("sc_readback", d, 32'hA5A50001);

    // 6: top of address space, then reset while a response is pending
    axi_read(12'h3FC, d, r);
    check("t6_top_rdata", d, 0);
    check("t6_top_rresp", r, ERR_RESP);
    awaddr = 12'h000; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge axilite_clk); @(negedge axilite_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("t6_bvalid_pending", bvalid, 1);
    check("t6_ctrl0_written", ctrl_regs[31:0], 32'h11111111);
    @(negedge axilite_clk);
    axilite_rst = 1'b1;
    @(posedge axilite_clk); @(negedge axilite_clk);
    #1;
    check("t6_bvalid_dropped", bvalid, 0);
    for (int i = 0; i < 8; i++) check($sformatf("t6_rst_reg%0d", i), ctrl_regs[32*i +: 32], 0);
    @(negedge axilite_clk);
    axilite_rst = 1'b0;
    $display("RST asserted with bvalid pending");
    @(negedge axilite_clk);
    axi_read(12'h004, d, r);
    check("t6_post_rst_read", d, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
